// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: programmable price/stock table, coin credit with
// overflow rejection, payment timeout, and sequenced dispense-then-change outputs.
module vending_machine_multi #(
    parameter int NUM_PRODUCTS   = 8,
    parameter int CODE_W         = 3,
    parameter int PRICE_W        = 8,
    parameter int STOCK_W        = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cfg_we,
    input  logic [CODE_W-1:0]  i_cfg_code,
    input  logic [PRICE_W-1:0] i_cfg_price,
    input  logic [STOCK_W-1:0] i_cfg_stock,
    input  logic               i_start,
    input  logic               i_select_valid,
    input  logic [CODE_W-1:0]  i_product_code,
    input  logic               i_coin_valid,
    input  logic [PRICE_W-1:0] i_coin_value,
    input  logic               i_online_payment,
    input  logic               i_cancel,
    output logic [2:0]         o_state,
    output logic [PRICE_W-1:0] o_product_price,
    output logic [PRICE_W-1:0] o_credit,
    output logic               o_coin_reject,
    output logic               o_select_err,
    output logic               o_dispense_valid,
    output logic [CODE_W-1:0]  o_dispense_code,
    output logic               o_change_valid,
    output logic [PRICE_W-1:0] o_change_value
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_PAY      = 3'd2,
        S_DISPENSE = 3'd3,
        S_CHANGE   = 3'd4,
        S_REFUND   = 3'd5
    } state_t;

    localparam int                  TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CODE_W:0]     NUM_CODES  = (CODE_W + 1)'(NUM_PRODUCTS);

    state_t               state, state_n;
    logic [PRICE_W-1:0]   price_tab [NUM_PRODUCTS];
    logic [STOCK_W-1:0]   stock_tab [NUM_PRODUCTS];

    logic [PRICE_W-1:0]   credit, credit_n;
    logic [PRICE_W-1:0]   change_amt, change_amt_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [CODE_W-1:0]    sel_code, sel_code_n;
    logic [PRICE_W-1:0]   sel_price, sel_price_n;

    logic                 coin_reject_n, select_err_n, dispense_valid_n, change_valid_n;
    logic [CODE_W-1:0]    dispense_code_n;
    logic [PRICE_W-1:0]   change_value_n, product_price_n;

    logic                 cfg_code_ok, sel_code_ok, sel_available;
    logic [PRICE_W:0]     coin_sum;
    logic                 coin_ok;
    logic [PRICE_W-1:0]   credit_paid;

    assign cfg_code_ok   = {1'b0, i_cfg_code} < NUM_CODES;
    assign sel_code_ok   = {1'b0, i_product_code} < NUM_CODES;
    assign sel_available = sel_code_ok && (stock_tab[i_product_code] != '0);

    // One extra bit catches credit overflow; credit_paid already includes an accepted coin.
    assign coin_sum    = {1'b0, credit} + {1'b0, i_coin_value};
    assign coin_ok     = i_coin_valid && !coin_sum[PRICE_W];
    assign credit_paid = coin_ok ? coin_sum[PRICE_W-1:0] : credit;

    assign o_state  = state;
    assign o_credit = credit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                price_tab[i] <= '0;
                stock_tab[i] <= '0;
            end
        end else if (state == S_IDLE && i_cfg_we && cfg_code_ok) begin
            price_tab[i_cfg_code] <= i_cfg_price;
            stock_tab[i_cfg_code] <= i_cfg_stock;
        end else if (state == S_DISPENSE) begin
            stock_tab[sel_code] <= stock_tab[sel_code] - STOCK_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            credit           <= '0;
            change_amt       <= '0;
            timer            <= '0;
            sel_code         <= '0;
            sel_price        <= '0;
            o_product_price  <= '0;
            o_coin_reject    <= 1'b0;
            o_select_err     <= 1'b0;
            o_dispense_valid <= 1'b0;
            o_dispense_code  <= '0;
            o_change_valid   <= 1'b0;
            o_change_value   <= '0;
        end else begin
            state            <= state_n;
            credit           <= credit_n;
            change_amt       <= change_amt_n;
            timer            <= timer_n;
            sel_code         <= sel_code_n;
            sel_price        <= sel_price_n;
            o_product_price  <= product_price_n;
            o_coin_reject    <= coin_reject_n;
            o_select_err     <= select_err_n;
            o_dispense_valid <= dispense_valid_n;
            o_dispense_code  <= dispense_code_n;
            o_change_valid   <= change_valid_n;
            o_change_value   <= change_value_n;
        end
    end

    // Output pulses are computed for the state being entered so they land registered in that state.
    always_comb begin
        state_n          = state;
        credit_n         = credit;
        change_amt_n     = change_amt;
        timer_n          = timer;
        sel_code_n       = sel_code;
        sel_price_n      = sel_price;
        coin_reject_n    = i_coin_valid;
        select_err_n     = 1'b0;
        dispense_valid_n = 1'b0;
        dispense_code_n  = o_dispense_code;
        change_valid_n   = 1'b0;
        change_value_n   = o_change_value;

        case (state)
            S_IDLE: begin
                if (i_start) state_n = S_SELECT;
            end
            S_SELECT: begin
                if (i_cancel) begin
                    state_n = S_IDLE;
                end else if (i_select_valid) begin
                    if (!sel_available) begin
                        select_err_n = 1'b1;
                    end else begin
                        sel_code_n  = i_product_code;
                        sel_price_n = price_tab[i_product_code];
                        timer_n     = '0;
                        state_n     = S_PAY;
                    end
                end
            end
            S_PAY: begin
                coin_reject_n = i_coin_valid && !coin_ok;
                credit_n      = credit_paid;
                timer_n       = coin_ok ? '0 : timer + TIMER_W'(1);
                if (i_cancel) begin
                    state_n        = S_REFUND;
                    change_amt_n   = credit_paid;
                    change_valid_n = (credit_paid != '0);
                    if (credit_paid != '0) change_value_n = credit_paid;
                end else if (i_online_payment || credit_paid >= sel_price) begin
                    state_n          = S_DISPENSE;
                    change_amt_n     = i_online_payment ? credit_paid : credit_paid - sel_price;
                    dispense_valid_n = 1'b1;
                    dispense_code_n  = sel_code;
                end else if (!coin_ok && timer == TIMER_LAST) begin
                    state_n        = S_REFUND;
                    change_amt_n   = credit_paid;
                    change_valid_n = (credit_paid != '0);
                    if (credit_paid != '0) change_value_n = credit_paid;
                end
            end
            S_DISPENSE: begin
                state_n        = S_CHANGE;
                change_valid_n = (change_amt != '0);
                if (change_amt != '0) change_value_n = change_amt;
            end
            S_CHANGE: begin
                credit_n = '0;
                state_n  = S_IDLE;
            end
            S_REFUND: begin
                credit_n = '0;
                state_n  = S_IDLE;
            end
            default: begin
                credit_n = '0;
                state_n  = S_IDLE;
            end
        endcase

        product_price_n = (state_n == S_PAY || state_n == S_DISPENSE || state_n == S_CHANGE)
                          ? sel_price_n : '0;
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: dispense/change events go through a scoreboard,
// everything else is checked with immediate assertions at each step.
module tb_vending_machine_multi;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cfg_we = 1'b0;
    logic [2:0] i_cfg_code = '0;
    logic [7:0] i_cfg_price = '0;
    logic [3:0] i_cfg_stock = '0;
    logic       i_start = 1'b0;
    logic       i_select_valid = 1'b0;
    logic [2:0] i_product_code = '0;
    logic       i_coin_valid = 1'b0;
    logic [7:0] i_coin_value = '0;
    logic       i_online_payment = 1'b0;
    logic       i_cancel = 1'b0;
    logic [2:0] o_state;
    logic [7:0] o_product_price;
    logic [7:0] o_credit;
    logic       o_coin_reject;
    logic       o_select_err;
    logic       o_dispense_valid;
    logic [2:0] o_dispense_code;
    logic       o_change_valid;
    logic [7:0] o_change_value;

    int passCount = 0;
    int totalCount = 0;
    int expDispense[$];
    int expChange[$];

    vending_machine_multi #(
        .NUM_PRODUCTS(5), .CODE_W(3), .PRICE_W(8), .STOCK_W(4), .TIMEOUT_CYCLES(10)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cfg_we(i_cfg_we), .i_cfg_code(i_cfg_code), .i_cfg_price(i_cfg_price),
        .i_cfg_stock(i_cfg_stock), .i_start(i_start), .i_select_valid(i_select_valid),
        .i_product_code(i_product_code), .i_coin_valid(i_coin_valid),
        .i_coin_value(i_coin_value), .i_online_payment(i_online_payment),
        .i_cancel(i_cancel), .o_state(o_state), .o_product_price(o_product_price),
        .o_credit(o_credit), .o_coin_reject(o_coin_reject), .o_select_err(o_select_err),
        .o_dispense_valid(o_dispense_valid), .o_dispense_code(o_dispense_code),
        .o_change_valid(o_change_valid), .o_change_value(o_change_value)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic sel, input logic [2:0] code,
                                 input logic coinv, input logic [7:0] coin,
                                 input logic online, input logic cancel);
        i_start = start; i_select_valid = sel; i_product_code = code;
        i_coin_valid = coinv; i_coin_value = coin;
        i_online_payment = online; i_cancel = cancel;
        tick();
        i_start = 1'b0; i_select_valid = 1'b0; i_product_code = '0;
        i_coin_valid = 1'b0; i_coin_value = '0;
        i_online_payment = 1'b0; i_cancel = 1'b0;
    endtask

    task automatic cfgWrite(input logic [2:0] code, input logic [7:0] price, input logic [3:0] stock);
        i_cfg_we = 1'b1; i_cfg_code = code; i_cfg_price = price; i_cfg_stock = stock;
        tick();
        i_cfg_we = 1'b0;
    endtask

    // Scoreboard side: every dispense/change pulse must match the oldest queued expectation.
    always @(negedge i_clk) begin
        if (o_dispense_valid === 1'b1) begin
            int exp;
            exp = (expDispense.size() > 0) ? expDispense.pop_front() : -1;
            checkOutput("dispense_code", 32'(o_dispense_code), 32'(exp));
        end
        if (o_change_valid === 1'b1) begin
            int exp;
            exp = (expChange.size() > 0) ? expChange.pop_front() : -1;
            checkOutput("change_value", 32'(o_change_value), 32'(exp));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(); tick();
        checkOutput("rst_state", 32'(o_state), 0);
        checkOutput("rst_credit", 32'(o_credit), 0);
        checkOutput("rst_price", 32'(o_product_price), 0);
        checkOutput("rst_dispense", 32'(o_dispense_valid), 0);
        checkOutput("rst_change_valid", 32'(o_change_valid), 0);
        checkOutput("rst_change_value", 32'(o_change_value), 0);
        i_rst_n = 1'b1;

        applyStimulus(0, 0, 0, 1, 8'd10, 0, 0);
        checkOutput("idle_coin_reject", 32'(o_coin_reject), 1);
        checkOutput("idle_coin_credit", 32'(o_credit), 0);

        // Product 2 at 35 with one in stock: 20+20 pays, 5 change, then sold out.
        cfgWrite(3'd2, 8'd35, 4'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("start_select", 32'(o_state), 1);
        applyStimulus(0, 1, 3'd2, 0, 0, 0, 0);
        checkOutput("sel2_state", 32'(o_state), 2);
        checkOutput("sel2_price", 32'(o_product_price), 35);
        applyStimulus(0, 0, 0, 1, 8'd20, 0, 0);
        checkOutput("coin20_credit", 32'(o_credit), 20);
        checkOutput("coin20_state", 32'(o_state), 2);
        expDispense.push_back(2); expChange.push_back(5);
        applyStimulus(0, 0, 0, 1, 8'd20, 0, 0);
        checkOutput("paid_dispense_state", 32'(o_state), 3);
        tick();
        checkOutput("paid_change_state", 32'(o_state), 4);
        checkOutput("paid_change_valid", 32'(o_change_valid), 1);
        tick();
        checkOutput("paid_idle_state", 32'(o_state), 0);
        checkOutput("paid_idle_credit", 32'(o_credit), 0);
        checkOutput("paid_idle_price", 32'(o_product_price), 0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd2, 0, 0, 0, 0);
        checkOutput("soldout_err", 32'(o_select_err), 1);
        checkOutput("soldout_state", 32'(o_state), 1);
        applyStimulus(0, 1, 3'd7, 0, 0, 0, 0);
        checkOutput("badcode_err", 32'(o_select_err), 1);
        checkOutput("badcode_state", 32'(o_state), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("select_cancel_state", 32'(o_state), 0);

        cfgWrite(3'd1, 8'd50, 4'd5);
        cfgWrite(3'd4, 8'd255, 4'd2);
        cfgWrite(3'd3, 8'd0, 4'd1);

        // Cancel with a same-cycle coin refunds both coins.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd1, 0, 0, 0, 0);
        checkOutput("sel1_price", 32'(o_product_price), 50);
        applyStimulus(0, 0, 0, 1, 8'd10, 0, 0);
        checkOutput("cancel_pre_credit", 32'(o_credit), 10);
        expChange.push_back(20);
        applyStimulus(0, 0, 0, 1, 8'd10, 0, 1);
        checkOutput("cancel_refund_state", 32'(o_state), 5);
        checkOutput("cancel_refund_valid", 32'(o_change_valid), 1);
        checkOutput("cancel_coin_reject", 32'(o_coin_reject), 0);
        tick();
        checkOutput("cancel_idle_state", 32'(o_state), 0);
        checkOutput("cancel_idle_credit", 32'(o_credit), 0);

        // Overflow: 250 + 10 refused, 250 + 5 = 255 accepted and pays price 255 exactly.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd4, 0, 0, 0, 0);
        checkOutput("sel4_price", 32'(o_product_price), 255);
        applyStimulus(0, 0, 0, 1, 8'd200, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'd50, 0, 0);
        checkOutput("ovf_credit250", 32'(o_credit), 250);
        applyStimulus(0, 0, 0, 1, 8'd10, 0, 0);
        checkOutput("ovf_reject", 32'(o_coin_reject), 1);
        checkOutput("ovf_credit_held", 32'(o_credit), 250);
        checkOutput("ovf_state", 32'(o_state), 2);
        expDispense.push_back(4);
        applyStimulus(0, 0, 0, 1, 8'd5, 0, 0);
        checkOutput("ovf_credit255", 32'(o_credit), 255);
        checkOutput("ovf_accept_reject", 32'(o_coin_reject), 0);
        checkOutput("ovf_dispense_state", 32'(o_state), 3);
        tick();
        checkOutput("ovf_no_change", 32'(o_change_valid), 0);
        tick();

        // Online payment returns the whole coin credit.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'd15, 0, 0);
        checkOutput("online_credit", 32'(o_credit), 15);
        expDispense.push_back(1); expChange.push_back(15);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("online_dispense_state", 32'(o_state), 3);
        tick();
        checkOutput("online_change_value", 32'(o_change_value), 15);
        tick();

        // Timeout: REFUND exactly 10 cycles after PAY entry, no pulse for zero credit.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("timeout_still_pay", 32'(o_state), 2);
        tick();
        checkOutput("timeout_refund_state", 32'(o_state), 5);
        checkOutput("timeout_no_change", 32'(o_change_valid), 0);
        checkOutput("timeout_change_held", 32'(o_change_value), 15);
        tick();
        checkOutput("timeout_idle", 32'(o_state), 0);

        // Zero-price product dispenses on the first PAY cycle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd3, 0, 0, 0, 0);
        checkOutput("free_pay_state", 32'(o_state), 2);
        expDispense.push_back(3);
        tick();
        checkOutput("free_dispense_state", 32'(o_state), 3);
        tick(); tick();

        // Reset while dispensing clears everything including the table.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd1, 0, 0, 0, 0);
        expDispense.push_back(1);
        applyStimulus(0, 0, 0, 1, 8'd50, 0, 0);
        checkOutput("pre_rst_state", 32'(o_state), 3);
        i_rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_state", 32'(o_state), 0);
        checkOutput("mid_rst_dispense", 32'(o_dispense_valid), 0);
        checkOutput("mid_rst_code", 32'(o_dispense_code), 0);
        checkOutput("mid_rst_credit", 32'(o_credit), 0);
        checkOutput("mid_rst_change_value", 32'(o_change_value), 0);
        checkOutput("mid_rst_price", 32'(o_product_price), 0);
        i_rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd1, 0, 0, 0, 0);
        checkOutput("table_cleared_err", 32'(o_select_err), 1);
        checkOutput("table_cleared_state", 32'(o_state), 1);
        tick();

        checkOutput("dispense_queue_empty", 32'(expDispense.size()), 0);
        checkOutput("change_queue_empty", 32'(expChange.size()), 0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised successor to the single-product-table vending controller. Adds a runtime-programmable price/stock table for up to NUM_PRODUCTS items, cycle-by-cycle coin accumulation with overflow rejection, a payment inactivity timeout, sold-out detection, and sequenced dispense-then-change outputs. It sits between the coin acceptor/keypad front end and the dispense/change actuators; all outputs are registered.

## Interface

- NUM_PRODUCTS, 8: number of table entries; valid codes are 0..NUM_PRODUCTS-1
- CODE_W, 3: product code width; 2^CODE_W >= NUM_PRODUCTS
- PRICE_W, 8: width of price, coin, credit and change values
- STOCK_W, 4: per-product stock counter width
- TIMEOUT_CYCLES, 1000: idle cycles in PAY before automatic refund; >= 2

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_cfg_we  in  1  table write strobe, honoured only in IDLE
- i_cfg_code  in  CODE_W  table entry to write
- i_cfg_price  in  PRICE_W  price to write
- i_cfg_stock  in  STOCK_W  stock count to write
- i_start  in  1  begin a transaction
- i_select_valid  in  1  product selection strobe
- i_product_code  in  CODE_W  selected product
- i_coin_valid  in  1  one coin presented this cycle
- i_coin_value  in  PRICE_W  value of presented coin
- i_online_payment  in  1  external payment confirmed
- i_cancel  in  1  abort and refund
- o_state  out  3  current state encoding
- o_product_price  out  PRICE_W  price of selected product, 0 outside PAY/DISPENSE/CHANGE
- o_credit  out  PRICE_W  accumulated coin credit
- o_coin_reject  out  1  1-cycle pulse: coin refused (overflow or not in PAY)
- o_select_err  out  1  1-cycle pulse: invalid code or sold out
- o_dispense_valid  out  1  1-cycle pulse: dispense o_dispense_code
- o_dispense_code  out  CODE_W  product being dispensed
- o_change_valid  out  1  1-cycle pulse: return o_change_value
- o_change_value  out  PRICE_W  change/refund amount, held until next pulse

## Operation

- States: IDLE=0, SELECT=1, PAY=2, DISPENSE=3, CHANGE=4, REFUND=5; others -> IDLE next cycle, clearing credit.
- Reset (i_rst_n low at a clock edge): state IDLE, all outputs 0, credit 0, timeout counter 0, every table entry price 0 and stock 0. Reset mid-transaction discards credit with no refund pulse.
- IDLE: i_cfg_we writes price/stock of i_cfg_code (ignored if code >= NUM_PRODUCTS); i_start -> SELECT. If both, write happens and start is taken. Coins in IDLE/SELECT pulse o_coin_reject.
- SELECT: i_cancel -> IDLE. Else on i_select_valid: code >= NUM_PRODUCTS or stock 0 -> o_select_err, remain SELECT; otherwise latch code and price, -> PAY.
- PAY, priority cancel > coin > online > paid-check:
  - i_cancel -> REFUND with refund = credit + same-cycle coin if that coin is acceptable.
  - Coin accepted when credit + value <= 2^PRICE_W-1 (PRICE_W+1-bit compare); else o_coin_reject, credit unchanged. Accepted coin resets timeout counter.
  - i_online_payment -> DISPENSE; change = entire coin credit (coins returned).
  - credit (after this cycle's coin) >= price -> DISPENSE; change = credit - price.
  - Timeout counter increments each cycle without accepted coin; reaching TIMEOUT_CYCLES -> REFUND.
  - Price 0 product dispenses on the first PAY cycle.
- DISPENSE (1 cycle): o_dispense_valid=1, o_dispense_code=latched code, stock[code] decrements; -> CHANGE.
- CHANGE (1 cycle): o_change_valid=1 only if change != 0; credit cleared; -> IDLE.
- REFUND (1 cycle): o_change_valid=1 only if refund != 0; credit cleared; -> IDLE.
- Stock never underflows (SELECT guards zero).

## Timing

- All outputs registered; pulses appear the cycle the FSM is in the named state, i.e. one cycle after the triggering input edge.
- Selection to PAY: 1 cycle. Paying coin at edge N: DISPENSE at N+1, CHANGE at N+2, IDLE at N+3.
- o_credit reflects accepted coin one cycle after i_coin_valid.
- Timeout: with no coins, REFUND entered exactly TIMEOUT_CYCLES cycles after PAY entry.
- Inputs are sampled every cycle; i_start/i_select_valid are levels sampled only in their state.

## Test plan

- Reset then cfg code 2 price 35 stock 1; start, select 2, coins 20,20 -> dispense code 2, change 5, stock 0; second select 2 -> o_select_err, stay SELECT.
- Select code 7 with NUM_PRODUCTS=5 -> o_select_err; select valid code -> PAY with o_product_price correct.
- PAY price 50, coins 10 then cancel with coin 10 same cycle -> REFUND, change 20, no dispense.
- Credit 250, coin 10 (PRICE_W=8) -> o_coin_reject, credit 250; coin 5 accepted -> 255.
- Credit 15, i_online_payment -> dispense, change 15; no coins, TIMEOUT_CYCLES=10 -> REFUND at cycle 10, no change pulse.
- i_rst_n low in DISPENSE -> next cycle IDLE, all outputs 0, table cleared.
